mdc_commutator: RTL
===================

Name: mdc_commutator

Overview:
- Delay-switch-delay commutator for the 32-point radix-2 MDC FFT pipeline; one instance per stage boundary.
- Sits between butterfly stage k and stage k+1. It is driven by the matching controller commutator flag (state1_com1_flag, state2_comN_flag, state3_comN_flag) on its swap input.
- Reorders the two parallel complex streams so that samples DELAY apart are paired on the top and bottom outputs for the next butterfly.

Parameters:
- DATA_W, 16, width of each real and imaginary component (signed two's complement).
- DELAY, 16, depth of each delay line in cycles. Use 16/8/4/2/1 per stage. Must be ≥1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input pair valid, from upstream butterfly
- swap  in  1  commutator select from controller; 1 = cross paths
- in_top_re  in  DATA_W  upper-path real input
- in_top_im  in  DATA_W  upper-path imag input
- in_bot_re  in  DATA_W  lower-path real input
- in_bot_im  in  DATA_W  lower-path imag input
- out_valid  out  1  output pair valid
- out_top_re  out  DATA_W  upper-path real output
- out_top_im  out  DATA_W  upper-path imag output
- out_bot_re  out  DATA_W  lower-path real output
- out_bot_im  out  DATA_W  lower-path imag output

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. Every register (delay lines, output registers, valid pipe) clears to 0 on reset.
- All outputs read 0 during reset and until the pipeline refills.
- Free-running datapath:
  - Delay lines shift every cycle, with no enable and no stall.
  - in_valid does not gate data. It only feeds the valid pipe.
- Input delay: top_d(t) = {in_top}(t−DELAY), held in a DELAY-deep shift register.
- Switch (combinational), using swap sampled in the same cycle as the data:
  - swap=0: x0 = top_d, x1 = in_bot.
  - swap=1: x0 = in_bot, x1 = top_d.
- Output delay: bot_d(t) = x1(t−DELAY), held in a second DELAY-deep shift register.
- Output register: each cycle, out_top ← x0 and out_bot ← bot_d. Real and imaginary parts take identical paths.
- Latency:
  - swap held 0: top→top and bot→bot take DELAY+1 cycles.
  - swap held 1: bot→top takes 1 cycle; top→bot takes 2·DELAY+1 cycles.
- out_valid: in_valid delayed DELAY+1 cycles through a plain shift register.
- No arithmetic. Data passes bit-exact with no sign or width change.
- swap toggling every cycle is legal. Each cycle's swap value applies only to that cycle's x0/x1 selection.
- Aligning swap to the data is the caller's responsibility. The block adds no flag retiming.
- Reset mid-frame: everything clears immediately. The first nonzero outputs appear exactly as from power-up. No partial-frame recovery.
- DELAY=1: each delay line is a single register; the same equations hold.

Decomposition:
- Shared package fft_pkg:
  - DATA_W default.
  - Per-stage DELAY constants STAGE1_DLY=16, STAGE2_DLY=8, STAGE3_DLY=4, STAGE4_DLY=2, STAGE5_DLY=1.
  - A complex_t packed struct {re, im}.
- One sub-module: delay_line (parameters WIDTH, DEPTH; ports clk, rst_n, d, q; async clear). Instantiate it twice for data (width 2·DATA_W) and once for valid (width 1, DEPTH+1 stages).

Test Plan:
- Reset check, DELAY=2: hold rst_n=0 with random inputs driven → all outputs and out_valid = 0. Release reset, drive in_valid=1 from cycle 0 → out_valid first rises in cycle 3.
- Pass-through, DELAY=2, swap=0 always, in_top_re=0x10+t, in_bot_re=0x20+t → in cycle t+3, out_top_re = 0x10+t and out_bot_re = 0x20+t.
- Cross, DELAY=2, swap=1 always → out_top_re(t+1) = 0x20+t and out_bot_re(t+5) = 0x10+t.
- Commutation, DELAY=2, swap=1 when t mod 4 ∈ {2,3}, same stimulus → output pairs (top,bot) are (0x12,0x10),(0x13,0x11) in cycles 5,6 and (0x26,0x24),(0x27,0x25) in cycles 7,8; the pattern repeats.
- Reset mid-stream: DELAY=16, pulse rst_n low for 1 cycle at cycle 20 → outputs 0 immediately; out_valid stays 0 for 17 cycles after release, then resumes with pass-through data that arrived post-reset.
- Imag path and signedness: DELAY=4, in_top_im=−32768, in_bot_im=32767, swap toggling → every output im value appears bit-exact at the cycle predicted by the same equations as the re path.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and types for the 32-point radix-2 MDC FFT pipeline.
//   FFT_DATA_W     : default width of each real/imag component
//   STAGEn_DLY     : commutator delay-line depth at each stage boundary
//   complex_t      : packed {re, im} sample
package fft_pkg;

  localparam int unsigned FFT_DATA_W = 16;

  localparam int unsigned STAGE1_DLY = 16;
  localparam int unsigned STAGE2_DLY = 8;
  localparam int unsigned STAGE3_DLY = 4;
  localparam int unsigned STAGE4_DLY = 2;
  localparam int unsigned STAGE5_DLY = 1;

  typedef struct packed {
    logic signed [FFT_DATA_W-1:0] re;
    logic signed [FFT_DATA_W-1:0] im;
  } complex_t;

endpackage

// File: rtl/delay_line.sv
// Free-running DEPTH-stage shift register with asynchronous clear.
//   clk, rst_n : clock, async active-low reset (clears every stage)
//   d          : WIDTH-bit input, captured every cycle
//   q          : d delayed by DEPTH cycles (last stage)
module delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam int unsigned SR_W = WIDTH * DEPTH;

  logic [SR_W-1:0]       sr_q;
  logic [SR_W-1:0]       sr_d;
  logic [SR_W+WIDTH-1:0] shift_c;

  // New sample enters at the low end; the oldest one falls off the top.
  assign shift_c = {sr_q, d};
  assign sr_d    = shift_c[SR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q[SR_W-1 -: WIDTH];

endmodule

// File: rtl/mdc_commutator.sv
// Delay-switch-delay commutator between two butterfly stages of the MDC FFT.
// Pairs samples DELAY apart onto the top/bottom outputs for the next stage.
//   clk, rst_n           : clock, async active-low reset
//   in_valid             : input pair valid (only feeds the valid pipe)
//   swap                 : 1 = cross the delayed-top and bottom paths this cycle
//   in_top_*, in_bot_*   : upper/lower complex inputs
//   out_valid            : in_valid delayed DELAY+1 cycles
//   out_top_*, out_bot_* : registered commutated outputs
module mdc_commutator
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = FFT_DATA_W,
  parameter int unsigned DELAY  = STAGE1_DLY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              swap,
  input  logic [DATA_W-1:0] in_top_re,
  input  logic [DATA_W-1:0] in_top_im,
  input  logic [DATA_W-1:0] in_bot_re,
  input  logic [DATA_W-1:0] in_bot_im,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_top_re,
  output logic [DATA_W-1:0] out_top_im,
  output logic [DATA_W-1:0] out_bot_re,
  output logic [DATA_W-1:0] out_bot_im
);

  localparam int unsigned CW = 2 * DATA_W;

  logic [CW-1:0] in_top;
  logic [CW-1:0] in_bot;
  logic [CW-1:0] top_dly;
  logic [CW-1:0] bot_dly;
  logic [CW-1:0] x0_c;
  logic [CW-1:0] x1_c;
  logic [CW-1:0] out_top_d, out_top_q;
  logic [CW-1:0] out_bot_d, out_bot_q;

  // Real and imaginary parts travel together as one {re, im} word.
  assign in_top = {in_top_re, in_top_im};
  assign in_bot = {in_bot_re, in_bot_im};

  // Input delay on the upper path.
  delay_line #(
    .WIDTH (CW),
    .DEPTH (DELAY)
  ) u_top_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in_top),
    .q     (top_dly)
  );

  // Switch: swap applies to the data present in the same cycle only.
  always_comb begin
    x0_c = top_dly;
    x1_c = in_bot;
    if (swap) begin
      x0_c = in_bot;
      x1_c = top_dly;
    end
  end

  // Output delay on the lower path.
  delay_line #(
    .WIDTH (CW),
    .DEPTH (DELAY)
  ) u_bot_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (x1_c),
    .q     (bot_dly)
  );

  // Valid pipe: one extra stage to match the output register.
  delay_line #(
    .WIDTH (1),
    .DEPTH (DELAY + 1)
  ) u_vld_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in_valid),
    .q     (out_valid)
  );

  assign out_top_d = x0_c;
  assign out_bot_d = bot_dly;

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_top_q <= '0;
      out_bot_q <= '0;
    end else begin
      out_top_q <= out_top_d;
      out_bot_q <= out_bot_d;
    end
  end

  assign out_top_re = out_top_q[CW-1 -: DATA_W];
  assign out_top_im = out_top_q[DATA_W-1:0];
  assign out_bot_re = out_bot_q[CW-1 -: DATA_W];
  assign out_bot_im = out_bot_q[DATA_W-1:0];

endmodule
